up_down_counter_host: RTL and testbench
=======================================

Name: up_down_counter_host

Overview:
- Bus-master sequencer that drives the up/down counter peripheral's register interface: active-low chip-select, read strobe, write strobe, two address lines, an 8-bit data bus and a start pulse.
- Per job it:
  - resets the counter;
  - writes PLR/ULR/LLR/CCR;
  - reads each register back and compares it;
  - checks the counter's error flag;
  - issues one start pulse;
  - waits for end-of-cycle (ec), then reports a status code.
- Sits between a controller/CPU command port and the counter instance.

Parameters:
- STROBE_CYCLES, 2, cycles nwr/nrd are held low per access; minimum 2.
- RESET_CYCLES, 2, cycles the counter's active-low reset is held low at job start.
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before a timeout abort; 16-bit.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- reset_in  input  1  synchronous, active-high reset.
- cmd_valid  input  1  job request.
- cmd_ready  output  1  high in IDLE only.
- cmd_plr, cmd_ulr, cmd_llr, cmd_ccr  input  8 each  register values for the job.
- done  output  1  one-cycle pulse when a job ends.
- status  output  3  0 OK, 1 BAD_CFG, 2 MISMATCH, 3 ERR_FLAG, 4 TIMEOUT; valid with done, held until next done.
- ncs_out, nrd_out, nwr_out  output  1 each  counter bus strobes, active low.
- a1_out, a0_out  output  1 each  register address: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
- bus_dout  output  8  write data.
- bus_doe  output  1  tristate enable for bus_dout onto the shared data bus.
- bus_din  input  8  data bus as seen by the host.
- cntr_nreset_out  output  1  active-low reset to the counter.
- start_out  output  1  counter start pulse.
- err_in, ec_in, dir_in  input  1 each  counter flags; x/z is treated as 0.
- count_in  input  8  counter value; monitored only.

Behaviour:
- Reset/idle values:
  - ncs/nrd/nwr/cntr_nreset = 1;
  - a = 00, bus_dout = 0, bus_doe = 0, start_out = 0;
  - done = 0, status = 0, state = IDLE, cmd_ready = 1.
- IDLE:
  - On cmd_valid & cmd_ready, latch all four cmd values and check them.
  - If not (LLR <= PLR <= ULR) or CCR == 0: done pulse next cycle, status = 1, no bus activity.
  - Otherwise go to CRST.
- CRST: ncs = 0 and cntr_nreset = 0 for RESET_CYCLES, then cntr_nreset = 1 and go to WR_SETUP with index 0.
- ncs stays 0 from CRST entry through DONE. It returns to 1 one cycle after DONE.
- Write access, index i = 0..3 in the order PLR, ULR, LLR, CCR:
  - WR_SETUP, 1 cycle: address = i, bus_dout = value, bus_doe = 1, nwr = 1.
  - WR_STROBE, STROBE_CYCLES: nwr = 0.
  - WR_HOLD, 1 cycle: nwr = 1, bus_doe still 1.
  - Next index, or RD_SETUP with i = 0 after CCR.
- Read access:
  - RD_SETUP, 1 cycle: address = i, bus_doe = 0.
  - RD_STROBE, STROBE_CYCLES: nrd = 0; bus_din is sampled on the last strobe cycle.
  - RD_HOLD, 1 cycle: nrd = 1.
  - Compare the sample with the latched value. On first mismatch: abort to DONE with status = 2; remaining reads are skipped.
- nrd and nwr are never low simultaneously. bus_doe is never 1 while nrd = 0.
- CHK: wait 1 cycle, then sample err_in. If 1 → DONE with status = 3. Else → START.
- START: start_out = 1 for exactly one cycle (the counter counts start-high clocks and requires exactly one), then RUN.
- RUN:
  - 16-bit cycle counter cleared on entry.
  - ec_in == 1 → DONE with status = 0.
  - err_in == 1 → DONE with status = 3.
  - Counter reaching TIMEOUT_CYCLES → DONE with status = 4.
  - If both ec_in and err_in are high in the same cycle, ec_in wins.
- DONE, 1 cycle:
  - done = 1; all strobes return to idle values one cycle later.
  - Always goes to IDLE; a new cmd is accepted no earlier than the cycle after DONE.
- cmd_valid is ignored outside IDLE.
- reset_in mid-job: next cycle all outputs take reset values, no done pulse, no status update. The counter itself is not reset until the next job's CRST.
- Nominal latency with defaults, cmd accept to start_out = 2 + 4×4 + 4×4 + 1 = 35 cycles.

Test Plan:
- Legal job: cmd PLR = 5, ULR = 8, LLR = 3, CCR = 2, counter model attached → write/read order 00, 01, 10, 11 with nwr low for 2 cycles each, one 1-cycle start_out, done when ec_in rises, status = 0.
- Illegal config: PLR = 9, ULR = 8 → done one cycle after accept, status = 1, ncs_out never low. Repeat with CCR = 0 → status = 1.
- Readback fault: model returns 0x00 for ULR → status = 2, no start_out, and the LLR/CCR reads never occur.
- Error flag: force err_in = 1 after the writes → status = 3 from CHK, no start_out. Force err_in = 1 during RUN → status = 3.
- Timeout: TIMEOUT_CYCLES = 20, ec_in held 0 → done exactly 20 cycles after RUN entry, status = 4.
- Reset mid-write: assert reset_in during the ULR strobe → next cycle all strobes = 1, bus_doe = 0, cmd_ready = 1, no done pulse. A following legal job completes with status = 0.

Source files
------------

// File: rtl/up_down_counter_host.sv
// Bus-master sequencer for the up/down counter peripheral: resets it, programs
// PLR/ULR/LLR/CCR, verifies them by readback, starts one count and reports a status.
module up_down_counter_host #(
  parameter int STROBE_CYCLES  = 2,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_plr,
  input  logic [7:0] cmd_ulr,
  input  logic [7:0] cmd_llr,
  input  logic [7:0] cmd_ccr,
  output logic       done,
  output logic [2:0] status,
  output logic       ncs_out,
  output logic       nrd_out,
  output logic       nwr_out,
  output logic       a1_out,
  output logic       a0_out,
  output logic [7:0] bus_dout,
  output logic       bus_doe,
  input  logic [7:0] bus_din,
  output logic       cntr_nreset_out,
  output logic       start_out,
  input  logic       err_in,
  input  logic       ec_in,
  input  logic       dir_in,
  input  logic [7:0] count_in
);

  typedef enum logic [3:0] {
    IDLE, CRST, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_STROBE, RD_HOLD,
    CHK, START, RUN, DONE
  } state_t;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_CFG  = 3'd1;
  localparam logic [2:0] ST_MISMATCH = 3'd2;
  localparam logic [2:0] ST_ERR_FLAG = 3'd3;
  localparam logic [2:0] ST_TIMEOUT  = 3'd4;

  localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      status_q, status_d;
  logic            jobActive_q, jobActive_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [7:0]      sample_q, sample_d;
  logic            cfgBad;

  // Direction and count are only observed by the controller, never acted upon.
  logic unusedMonitor;
  assign unusedMonitor = ^{dir_in, count_in};

  assign cfgBad = !((cmd_llr <= cmd_plr) && (cmd_plr <= cmd_ulr)) || (cmd_ccr == 8'd0);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      status_q    <= ST_OK;
      jobActive_q <= 1'b0;
      regs_q      <= '0;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      status_q    <= status_d;
      jobActive_q <= jobActive_d;
      regs_q      <= regs_d;
      sample_q    <= sample_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    status_d    = status_q;
    jobActive_d = jobActive_q;
    regs_d      = regs_q;
    sample_d    = sample_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          regs_d = {cmd_ccr, cmd_llr, cmd_ulr, cmd_plr};
          if (cfgBad) begin
            status_d = ST_BAD_CFG;
            state_d  = DONE;
          end else begin
            cnt_d       = '0;
            jobActive_d = 1'b1;
            state_d     = CRST;
          end
        end
      end
      CRST: begin
        if (cnt_q == RESET_LAST) begin
          idx_d   = 2'd0;
          state_d = WR_SETUP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_STROBE;
      end
      WR_STROBE: begin
        if (cnt_q == STROBE_LAST) state_d = WR_HOLD;
        else cnt_d = cnt_q + 16'd1;
      end
      WR_HOLD: begin
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = RD_SETUP;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = WR_SETUP;
        end
      end
      RD_SETUP: begin
        cnt_d   = '0;
        state_d = RD_STROBE;
      end
      RD_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          sample_d = bus_din;
          state_d  = RD_HOLD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // First readback mismatch aborts; later registers are never read.
      RD_HOLD: begin
        if (sample_q != regs_q[idx_q]) begin
          status_d = ST_MISMATCH;
          state_d  = DONE;
        end else if (idx_q == 2'd3) begin
          state_d = CHK;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = RD_SETUP;
        end
      end
      CHK: begin
        if (err_in == 1'b1) begin
          status_d = ST_ERR_FLAG;
          state_d  = DONE;
        end else begin
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      // End-of-cycle takes priority over a simultaneous error flag.
      RUN: begin
        if (ec_in == 1'b1) begin
          status_d = ST_OK;
          state_d  = DONE;
        end else if (err_in == 1'b1) begin
          status_d = ST_ERR_FLAG;
          state_d  = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        jobActive_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready       = (state_q == IDLE);
    done            = (state_q == DONE);
    status          = status_q;
    ncs_out         = !jobActive_q;
    nrd_out         = 1'b1;
    nwr_out         = 1'b1;
    a1_out          = 1'b0;
    a0_out          = 1'b0;
    bus_dout        = 8'h00;
    bus_doe         = 1'b0;
    cntr_nreset_out = 1'b1;
    start_out       = 1'b0;
    case (state_q)
      CRST: cntr_nreset_out = 1'b0;
      WR_SETUP, WR_STROBE, WR_HOLD: begin
        {a1_out, a0_out} = idx_q;
        bus_dout         = regs_q[idx_q];
        bus_doe          = 1'b1;
        nwr_out          = (state_q != WR_STROBE);
      end
      RD_SETUP, RD_STROBE, RD_HOLD: begin
        {a1_out, a0_out} = idx_q;
        nrd_out          = (state_q != RD_STROBE);
      end
      START: start_out = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_up_down_counter_host.sv
// Randomized bench for up_down_counter_host with a behavioural counter-peripheral
// model and a rule-level job-outcome predictor.
module tb_up_down_counter_host;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_plr, cmd_ulr, cmd_llr, cmd_ccr;
  logic       done;
  logic [2:0] status;
  logic       ncs_out, nrd_out, nwr_out, a1_out, a0_out;
  logic [7:0] bus_dout;
  logic       bus_doe;
  logic [7:0] bus_din;
  logic       cntr_nreset_out, start_out;
  logic       err_in, ec_in;
  logic       dir_in;
  logic [7:0] count_in;

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;

  // Peripheral model state and fault knobs
  logic [7:0] pr [4];
  bit         faultOn, errChk, errRun, ecArm;
  logic [1:0] faultSel;
  int         ecDelay, ecAt;

  // Monitor logs, cleared per job
  int          wrRun, rdRun, wrCount, rdCount, badLen, violations;
  int          startCount, startCyc, doneCount, doneCyc;
  logic [31:0] wrCode, rdCode;
  logic [1:0]  wrAddr, rdAddr;
  bit          ncsLow;
  logic [2:0]  doneStatus;

  up_down_counter_host #(
    .STROBE_CYCLES(2), .RESET_CYCLES(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_plr(cmd_plr), .cmd_ulr(cmd_ulr), .cmd_llr(cmd_llr), .cmd_ccr(cmd_ccr),
    .done(done), .status(status), .ncs_out(ncs_out), .nrd_out(nrd_out), .nwr_out(nwr_out),
    .a1_out(a1_out), .a0_out(a0_out), .bus_dout(bus_dout), .bus_doe(bus_doe),
    .bus_din(bus_din), .cntr_nreset_out(cntr_nreset_out), .start_out(start_out),
    .err_in(err_in), .ec_in(ec_in), .dir_in(dir_in), .count_in(count_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign bus_din = (!ncs_out && !nrd_out)
                 ? ((faultOn && {a1_out, a0_out} == faultSel) ? 8'h00 : pr[{a1_out, a0_out}])
                 : 8'h00;
  assign err_in  = errChk || (errRun && startCount > 0);
  assign ec_in   = ecArm && (startCount > 0) && (cycle >= ecAt);

  // Peripheral register file plus bus-protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!cntr_nreset_out) for (int i = 0; i < 4; i++) pr[i] = 8'h00;
    if (!ncs_out && !nwr_out) pr[{a1_out, a0_out}] = bus_dout;
    if (!ncs_out) ncsLow = 1'b1;
    if (!nwr_out && !nrd_out) violations++;
    if (bus_doe && !nrd_out) violations++;
    if (!nwr_out) begin
      wrRun++;
      wrAddr = {a1_out, a0_out};
    end else if (wrRun != 0) begin
      wrCode |= (32'(wrAddr) + 32'd1) << (4 * wrCount);
      if (wrRun != 2) badLen++;
      wrCount++;
      wrRun = 0;
    end
    if (!nrd_out) begin
      rdRun++;
      rdAddr = {a1_out, a0_out};
    end else if (rdRun != 0) begin
      rdCode |= (32'(rdAddr) + 32'd1) << (4 * rdCount);
      if (rdRun != 2) badLen++;
      rdCount++;
      rdRun = 0;
    end
    if (start_out) begin
      startCount++;
      startCyc = cycle;
      ecAt     = cycle + ecDelay;
    end
    if (done) begin
      doneCount++;
      doneCyc    = cycle;
      doneStatus = status;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] accessCode(input int n);
    logic [31:0] c = '0;
    for (int i = 0; i < n; i++) c |= (32'(i) + 32'd1) << (4 * i);
    return c;
  endfunction

  task automatic clearLogs();
    wrRun = 0; rdRun = 0; wrCount = 0; rdCount = 0; badLen = 0; violations = 0;
    startCount = 0; startCyc = 0; doneCount = 0; doneCyc = 0;
    wrCode = '0; rdCode = '0; ncsLow = 1'b0; doneStatus = '0;
  endtask

  // Runs one job and checks it against outcome rules derived from the job's inputs
  task automatic applyStimulus(input logic [7:0] plr, ulr, llr, ccr,
                               input bit fault, input logic [1:0] fAddr,
                               input bit eChk, input bit eRun, input bit eArm, input int eDelay);
    bit legal, faultEff, expStart;
    logic [7:0] vals [4];
    int expStatus, expReads, n;
    vals[0] = plr; vals[1] = ulr; vals[2] = llr; vals[3] = ccr;
    legal    = (llr <= plr) && (plr <= ulr) && (ccr != 0);
    faultEff = legal && fault && (vals[fAddr] != 8'h00);
    if (!legal) expStatus = 1;
    else if (faultEff) expStatus = 2;
    else if (eChk) expStatus = 3;
    else if (eRun) expStatus = (eArm && eDelay == 0) ? 0 : 3;
    else if (!eArm) expStatus = 4;
    else expStatus = 0;
    expStart = legal && !faultEff && !eChk;
    expReads = !legal ? 0 : (faultEff ? int'(fAddr) + 1 : 4);

    @(negedge clk); #1;
    clearLogs();
    faultOn = fault; faultSel = fAddr; errChk = eChk; errRun = eRun;
    ecArm = eArm; ecDelay = eDelay; ecAt = 0;
    checkOutput("ready", {31'd0, cmd_ready}, 32'd1);
    cmd_plr = plr; cmd_ulr = ulr; cmd_llr = llr; cmd_ccr = ccr;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    if (!legal) checkOutput("badcfg_latency", n, 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("status", {29'd0, doneStatus}, expStatus);
    checkOutput("status_held", {29'd0, status}, expStatus);
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("start_pulses", startCount, expStart ? 1 : 0);
    checkOutput("ncs_low", {31'd0, ncsLow}, {31'd0, legal});
    checkOutput("write_order", wrCode, accessCode(legal ? 4 : 0));
    checkOutput("read_order", rdCode, accessCode(expReads));
    checkOutput("strobe_len", badLen, 0);
    checkOutput("protocol", violations, 0);
    if (legal) checkOutput("regs_written", {pr[0], pr[1], pr[2], pr[3]}, {plr, ulr, llr, ccr});
    if (expStatus == 4) checkOutput("timeout_cycles", doneCyc - startCyc, TMO + 1);
    errChk = 1'b0; errRun = 1'b0; faultOn = 1'b0;
  endtask

  task automatic randomJob();
    logic [7:0] p, u, l, c;
    int mode;
    if ($urandom_range(0, 9) < 7) begin
      l = 8'($urandom_range(0, 100));
      p = l + 8'($urandom_range(0, 50));
      u = p + 8'($urandom_range(0, 50));
      c = 8'($urandom_range(1, 255));
    end else begin
      p = 8'($urandom); u = 8'($urandom); l = 8'($urandom); c = 8'($urandom_range(0, 3));
    end
    mode = $urandom_range(0, 9);
    applyStimulus(p, u, l, c, mode == 0, 2'($urandom_range(0, 3)), mode == 1, mode == 2,
                  mode != 3, $urandom_range(1, 12));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset_in = 1'b1; cmd_valid = 1'b0;
    cmd_plr = '0; cmd_ulr = '0; cmd_llr = '0; cmd_ccr = '0;
    dir_in = 1'b0; count_in = '0;
    faultOn = 1'b0; faultSel = '0; errChk = 1'b0; errRun = 1'b0; ecArm = 1'b0;
    ecDelay = 0; ecAt = 0;
    for (int i = 0; i < 4; i++) pr[i] = 8'h00;
    clearLogs();
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    checkOutput("reset_ctrl",
                {22'd0, cmd_ready, ncs_out, nrd_out, nwr_out, cntr_nreset_out,
                 a1_out, a0_out, bus_doe, start_out, done},
                {22'd0, 10'b1111100000});
    checkOutput("reset_status", {29'd0, status}, 32'd0);
    checkOutput("reset_dout", {24'd0, bus_dout}, 32'd0);

    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6);  // legal
    applyStimulus(8'd9, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6);  // PLR > ULR
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 6);  // CCR = 0
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 6);  // ULR readback fault
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 6);  // err at CHK
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6);  // err in RUN
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 0);  // ec and err together
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0);  // timeout
    applyStimulus(8'd7, 8'd7, 8'd7, 8'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3);  // equal limits

    // Reset in the middle of the ULR write strobe
    @(negedge clk); #1;
    clearLogs();
    ecArm = 1'b1; ecDelay = 4;
    cmd_plr = 8'd5; cmd_ulr = 8'd8; cmd_llr = 8'd3; cmd_ccr = 8'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(!nwr_out && {a1_out, a0_out} == 2'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ulr_strobe_seen", {31'd0, n < 200}, 32'd1);
    reset_in = 1'b1;
    @(negedge clk);
    checkOutput("midreset_outputs",
                {25'd0, ncs_out, nrd_out, nwr_out, bus_doe, cmd_ready, done, start_out},
                {25'd0, 7'b1110100});
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midreset_no_done", doneCount, 0);
    applyStimulus(8'd5, 8'd8, 8'd3, 8'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5);

    for (int j = 0; j < 14; j++) randomJob();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
